// File: rtl/mmcm_drp_ctrl_pkg.sv
// Shared types and the configuration ROM contents for the MMCM DRP reconfiguration controller.
// Each table entry is a read-modify-write: mask bit 1 keeps the bit read back from the MMCM.
package mmcm_drp_pkg;

  localparam int NUM_CFG    = 4;
  localparam int NUM_REGS   = 8;
  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;
  localparam int CFG_W      = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  // One bit wider than a legal index so out-of-range requests can be expressed and rejected.
  localparam int CFG_SEL_W  = $clog2(NUM_CFG + 1);
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ASSERT_RST,
    ST_ROM_RD,
    ST_DRP_READ,
    ST_WAIT_RD,
    ST_DRP_WRITE,
    ST_WAIT_WR,
    ST_RELEASE,
    ST_WAIT_LOCK,
    ST_DONE,
    ST_ERROR
  } drp_state_t;

  typedef struct packed {
    logic [DRP_ADDR_W-1:0] addr;
    logic [DRP_DATA_W-1:0] mask;
    logic [DRP_DATA_W-1:0] data;
  } drp_entry_t;

  localparam drp_entry_t CFG_TABLE [NUM_CFG][NUM_REGS] = '{
    '{ '{7'h08, 16'h1000, 16'h0104}, '{7'h09, 16'hFC00, 16'h0040}, '{7'h0A, 16'h1000, 16'h0145},
       '{7'h0B, 16'hFC00, 16'h0000}, '{7'h14, 16'h1000, 16'h0410}, '{7'h15, 16'hFC00, 16'h0080},
       '{7'h16, 16'hC000, 16'h1041}, '{7'h18, 16'hFC00, 16'h00FA} },
    '{ '{7'h08, 16'h1000, 16'h0145}, '{7'h09, 16'hFC00, 16'h0080}, '{7'h0A, 16'h1000, 16'h0104},
       '{7'h0B, 16'hFC00, 16'h0000}, '{7'h14, 16'h1000, 16'h0208}, '{7'h15, 16'hFC00, 16'h0040},
       '{7'h16, 16'hC000, 16'h1041}, '{7'h18, 16'hFC00, 16'h00FA} },
    '{ '{7'h08, 16'h1000, 16'h0186}, '{7'h09, 16'hFC00, 16'h0000}, '{7'h0A, 16'h1000, 16'h0082},
       '{7'h0B, 16'hFC00, 16'h0000}, '{7'h14, 16'h1000, 16'h0145}, '{7'h15, 16'hFC00, 16'h0040},
       '{7'h16, 16'hC000, 16'h1041}, '{7'h18, 16'hFC00, 16'h007D} },
    '{ '{7'h08, 16'h1000, 16'h0208}, '{7'h09, 16'hFC00, 16'h0080}, '{7'h0A, 16'h1000, 16'h0104},
       '{7'h0B, 16'hFC00, 16'h0040}, '{7'h14, 16'h1000, 16'h0186}, '{7'h15, 16'hFC00, 16'h0000},
       '{7'h16, 16'hC000, 16'h1041}, '{7'h18, 16'hFC00, 16'h00C8} }
  };

  function automatic logic [DRP_DATA_W-1:0] merge_wdata(input logic [DRP_DATA_W-1:0] rd,
                                                        input drp_entry_t e);
    return (rd & e.mask) | (e.data & ~e.mask);
  endfunction

endpackage

// File: rtl/mmcm_drp_ctrl_if.sv
// DRP bus plus MMCM reset/lock, seen from the controller (master) or the MMCM (slave).
interface mmcm_drp_ctrl_if;
  import mmcm_drp_pkg::*;

  // o_den is a one-cycle request (o_dwe qualifies it as a write); the MMCM answers each
  // request with exactly one i_drdy pulse, carrying i_do for reads. No new request until then.
  logic [DRP_ADDR_W-1:0] o_daddr;
  logic [DRP_DATA_W-1:0] o_di;
  logic                  o_den;
  logic                  o_dwe;
  logic [DRP_DATA_W-1:0] i_do;
  logic                  i_drdy;
  logic                  o_mmcm_rst;
  logic                  i_locked;

  modport master (
    output o_daddr, o_di, o_den, o_dwe, o_mmcm_rst,
    input  i_do, i_drdy, i_locked
  );

  modport slave (
    input  o_daddr, o_di, o_den, o_dwe, o_mmcm_rst,
    output i_do, i_drdy, i_locked
  );

endinterface

// File: rtl/mmcm_drp_ctrl_rom.sv
// Registered lookup of the configuration table; the entry appears one cycle after en_i.
module mmcm_drp_rom
  import mmcm_drp_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [CFG_W-1:0] cfg_i,
  input  logic [IDX_W-1:0] idx_i,
  output drp_entry_t       entry_o
);

  drp_entry_t entry_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else if (en_i) begin
      entry_q <= CFG_TABLE[cfg_i][idx_i];
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// MMCM runtime reconfiguration sequencer: holds the MMCM in reset, read-modify-writes every
// DRP register of the chosen configuration, releases reset and waits for lock.
module mmcm_drp_ctrl
  import mmcm_drp_pkg::*;
#(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_reconfig_req,
  input  logic [CFG_SEL_W-1:0] i_cfg_sel,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic                 o_locked,
  output drp_state_t           o_state,
  mmcm_drp_ctrl_if.master      drp
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);

  drp_state_t            state_q;
  logic [CFG_W-1:0]      cfg_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q, done_q, error_q, mmcm_rst_q, den_q, dwe_q;
  logic [DRP_DATA_W-1:0] di_q;
  drp_entry_t            entry;
  logic                  rom_en;
  logic                  cfg_ok;

  assign rom_en = (state_q == ST_ROM_RD);
  assign cfg_ok = (i_cfg_sel < CFG_SEL_W'(NUM_CFG));

  mmcm_drp_rom u_rom (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .en_i    (rom_en),
    .cfg_i   (cfg_q),
    .idx_i   (idx_q),
    .entry_o (entry)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_RELEASE;
      cfg_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mmcm_rst_q <= 1'b1;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      di_q       <= '0;
    end else begin
      den_q  <= 1'b0;
      dwe_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_reconfig_req) begin
            cfg_q      <= i_cfg_sel[CFG_W-1:0];
            idx_q      <= '0;
            mmcm_rst_q <= 1'b1;
            if (cfg_ok) begin
              state_q <= ST_ASSERT_RST;
              busy_q  <= 1'b1;
              error_q <= 1'b0;
            end else begin
              state_q <= ST_ERROR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end else if (state_q == ST_DONE) begin
            state_q <= ST_IDLE;
          end
        end
        ST_ASSERT_RST: state_q <= ST_ROM_RD;
        ST_ROM_RD: begin
          state_q <= ST_DRP_READ;
          den_q   <= 1'b1;
        end
        // The DEN cycle itself counts toward the DRDY budget, so wait states start at 1.
        ST_DRP_READ: begin
          state_q <= ST_WAIT_RD;
          cnt_q   <= CNT_W'(1);
        end
        ST_WAIT_RD: begin
          if (drp.i_drdy) begin
            di_q    <= merge_wdata(drp.i_do, entry);
            state_q <= ST_DRP_WRITE;
            den_q   <= 1'b1;
            dwe_q   <= 1'b1;
          end else if (cnt_q == DRDY_LAST) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DRP_WRITE: begin
          state_q <= ST_WAIT_WR;
          cnt_q   <= CNT_W'(1);
        end
        ST_WAIT_WR: begin
          if (drp.i_drdy) begin
            if (idx_q == IDX_LAST) begin
              state_q <= ST_RELEASE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_ROM_RD;
            end
          end else if (cnt_q == DRDY_LAST) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          mmcm_rst_q <= 1'b0;
          state_q    <= ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (drp.i_locked) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (cnt_q == LOCK_LAST) begin
            state_q    <= ST_ERROR;
            error_q    <= 1'b1;
            busy_q     <= 1'b0;
            mmcm_rst_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_ERROR;
          error_q    <= 1'b1;
          busy_q     <= 1'b0;
          mmcm_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign drp.o_daddr    = entry.addr;
  assign drp.o_di       = di_q;
  assign drp.o_den      = den_q;
  assign drp.o_dwe      = dwe_q;
  assign drp.o_mmcm_rst = mmcm_rst_q;

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_error  = error_q;
  assign o_state  = state_q;
  assign o_locked = drp.i_locked && ((state_q == ST_IDLE) || (state_q == ST_DONE));

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Directed bench for mmcm_drp_ctrl with a behavioural MMCM DRP/lock model.
module tb_mmcm_drp_ctrl;
  import mmcm_drp_pkg::*;

  localparam int TB_DRDY_TO = 64;
  localparam int TB_LOCK_TO = 400;
  localparam int LOCK_DELAY = 100;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 req;
  logic [CFG_SEL_W-1:0] cfg_sel;
  logic                 busy, done, error, locked_o;
  drp_state_t           state;

  mmcm_drp_ctrl_if drp_if ();

  mmcm_drp_ctrl #(
    .DRDY_TIMEOUT (TB_DRDY_TO),
    .LOCK_TIMEOUT (TB_LOCK_TO)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_reconfig_req (req),
    .i_cfg_sel      (cfg_sel),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error),
    .o_locked       (locked_o),
    .o_state        (state),
    .drp            (drp_if.master)
  );

  // scoreboard
  logic [23:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int den_count = 0;
  int done_count = 0;
  int rst_bad = 0;
  int dwe_bad = 0;
  bit answer = 1'b1;
  bit lock_en = 1'b1;
  logic [15:0] rd_val = 16'hFFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // MMCM model: answers DEN two cycles later, raises LOCKED LOCK_DELAY cycles after RST falls.
  initial begin : drp_model
    int drdy_wait;
    int lock_cnt;
    logic [23:0] obs;
    drdy_wait = 0;
    lock_cnt = 0;
    drp_if.i_drdy = 1'b0;
    drp_if.i_do = '0;
    drp_if.i_locked = 1'b0;
    forever begin
      @(negedge clk);
      drp_if.i_drdy = 1'b0;
      if (drdy_wait > 0) begin
        drdy_wait--;
        if (drdy_wait == 0) begin
          drp_if.i_drdy = 1'b1;
          drp_if.i_do = rd_val;
        end
      end
      if (drp_if.o_dwe && !drp_if.o_den) dwe_bad++;
      if (drp_if.o_den) begin
        den_count++;
        if (!drp_if.o_mmcm_rst) rst_bad++;
        obs = {drp_if.o_dwe, drp_if.o_daddr, drp_if.o_dwe ? drp_if.o_di : 16'h0000};
        if (exp_q.size() > 0) check("drp_txn", 32'(obs), 32'(exp_q.pop_front()));
        if (answer) drdy_wait = 2;
      end
      if (done) done_count++;
      if (drp_if.o_mmcm_rst) begin
        drp_if.i_locked = 1'b0;
        lock_cnt = 0;
      end else if (lock_en && !drp_if.i_locked) begin
        lock_cnt++;
        if (lock_cnt >= LOCK_DELAY) drp_if.i_locked = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [CFG_SEL_W-1:0] sel);
    req = 1'b1;
    cfg_sel = sel;
    tick();
    req = 1'b0;
    cfg_sel = '0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = done;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // cfg 1 against a read value of FFFF: reads carry 0 data, writes carry hand-merged data
  task automatic push_cfg1();
    logic [23:0] v [16];
    v = '{24'h080000, 24'h881145, 24'h090000, 24'h89FC80,
          24'h0A0000, 24'h8A1104, 24'h0B0000, 24'h8BFC00,
          24'h140000, 24'h941208, 24'h150000, 24'h95FC40,
          24'h160000, 24'h96D041, 24'h180000, 24'h98FCFA};
    foreach (v[i]) exp_q.push_back(v[i]);
  endtask

  initial begin : main
    int base;
    int n;
    rst = 1'b1;
    req = 1'b0;
    cfg_sel = '0;

    // reset values
    repeat (3) tick();
    check("rst_mmcm_rst", 32'(drp_if.o_mmcm_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_den", 32'(drp_if.o_den), 32'd0);
    check("rst_dwe", 32'(drp_if.o_dwe), 32'd0);
    check("rst_daddr", 32'(drp_if.o_daddr), 32'd0);
    check("rst_di", 32'(drp_if.o_di), 32'd0);
    check("rst_locked", 32'(locked_o), 32'd0);
    check("rst_state", 32'(state), 32'(ST_RELEASE));

    // power-on
    rst = 1'b0;
    tick();
    check("pwr_rst_low_cycle1", 32'(drp_if.o_mmcm_rst), 32'd0);
    wait_done("pwr_done", 300);
    repeat (2) tick();
    check("pwr_done_pulses", 32'(done_count), 32'd1);
    check("pwr_locked", 32'(locked_o), 32'd1);
    check("pwr_busy", 32'(busy), 32'd0);
    check("pwr_no_den", 32'(den_count), 32'd0);

    // reconfig cfg 1, with a request pulsed mid-sequence
    push_cfg1();
    base = den_count;
    request(3'd1);
    check("cfg_busy_accept", 32'(busy), 32'd1);
    check("cfg_mmcm_rst_accept", 32'(drp_if.o_mmcm_rst), 32'd1);
    check("cfg_locked_low", 32'(locked_o), 32'd0);
    repeat (10) tick();
    request(3'd2);
    wait_done("cfg_done", 1000);
    check("cfg_den_pulses", 32'(den_count - base), 32'd16);
    check("cfg_exp_left", 32'(exp_q.size()), 32'd0);
    check("cfg_busy_done", 32'(busy), 32'd0);

    // DRDY timeout, request issued while in DONE
    answer = 1'b0;
    base = den_count;
    request(3'd0);
    for (int i = 0; i < 20 && !drp_if.o_den; i++) tick();
    check("to_den_seen", 32'(drp_if.o_den), 32'd1);
    n = 0;
    while (!error && n < 200) begin
      tick();
      n++;
    end
    check("drdy_to_cycles", 32'(n), 32'(TB_DRDY_TO));
    check("to_mmcm_rst", 32'(drp_if.o_mmcm_rst), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_locked", 32'(locked_o), 32'd0);
    check("to_den_pulses", 32'(den_count - base), 32'd1);

    // lock timeout
    answer = 1'b1;
    lock_en = 1'b0;
    push_cfg1();
    base = den_count;
    request(3'd1);
    check("lk_err_clear", 32'(error), 32'd0);
    for (int i = 0; i < 300 && drp_if.o_mmcm_rst; i++) tick();
    check("lk_rst_fell", 32'(drp_if.o_mmcm_rst), 32'd0);
    n = 0;
    while (!error && n < 1000) begin
      tick();
      n++;
    end
    check("lock_to_cycles", 32'(n), 32'(TB_LOCK_TO));
    check("lk_den_pulses", 32'(den_count - base), 32'd16);
    check("lk_exp_left", 32'(exp_q.size()), 32'd0);
    check("lk_mmcm_rst", 32'(drp_if.o_mmcm_rst), 32'd1);

    // recovery from error
    lock_en = 1'b1;
    base = den_count;
    request(3'd2);
    check("rec_err_clear", 32'(error), 32'd0);
    check("rec_busy", 32'(busy), 32'd1);
    wait_done("rec_done", 1000);
    check("rec_den_pulses", 32'(den_count - base), 32'd16);
    tick();
    check("rec_locked", 32'(locked_o), 32'd1);

    // illegal configuration index
    tick();
    base = den_count;
    request(CFG_SEL_W'(NUM_CFG));
    check("ill_error", 32'(error), 32'd1);
    check("ill_busy", 32'(busy), 32'd0);
    check("ill_state", 32'(state), 32'(ST_ERROR));
    repeat (5) tick();
    check("ill_no_den", 32'(den_count - base), 32'd0);

    // reset mid-write
    request(3'd1);
    for (int i = 0; i < 50 && state != ST_WAIT_WR; i++) tick();
    check("mr_in_wait_wr", 32'(state), 32'(ST_WAIT_WR));
    rst = 1'b1;
    #1;
    check("mr_den", 32'(drp_if.o_den), 32'd0);
    check("mr_mmcm_rst", 32'(drp_if.o_mmcm_rst), 32'd1);
    check("mr_state", 32'(state), 32'(ST_RELEASE));
    base = den_count;
    repeat (2) tick();
    rst = 1'b0;
    wait_done("mr_done", 300);
    check("mr_no_den", 32'(den_count - base), 32'd0);

    check("rst_during_den", 32'(rst_bad), 32'd0);
    check("dwe_without_den", 32'(dwe_bad), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
